// File: rtl/kyber_bram_pkg.sv
// Shared definitions for the Kyber BRAM coefficient engine.
//   Q, DEPTH, address widths, CSR word addresses, mode encodings,
//   engine FSM state type and a single conditional-subtract helper.
package kyber_bram_pkg;

  localparam int unsigned Q      = 3329;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned AW     = 10;
  localparam int unsigned CSR_AW = 13;

  localparam logic [CSR_AW-1:0] ADDR_CTRL   = 13'd1;
  localparam logic [CSR_AW-1:0] ADDR_MODE   = 13'd3;
  localparam logic [CSR_AW-1:0] ADDR_STATUS = 13'd4;

  localparam logic [1:0] MODE_COPY = 2'd0;
  localparam logic [1:0] MODE_ADD  = 2'd1;
  localparam logic [1:0] MODE_MUL  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_CALC,
    ST_WR,
    ST_DONE
  } state_t;

  // Brings any value in [0, 2Q) into [0, Q).
  function automatic logic [11:0] reduce_once(input logic [12:0] x);
    return (x >= 13'(Q)) ? 12'(x - 13'(Q)) : x[11:0];
  endfunction

endpackage

// File: rtl/kyber_modmul.sv
// 12x12-bit modular multiplier, r = (a * b) mod Q, one cycle latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   a, b       : operands, each already in [0, Q)
//   r          : registered product mod Q
module kyber_modmul
  import kyber_bram_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [11:0] r
);

  // floor(2^24 / Q). For products below Q^2 the quotient estimate is at most
  // one short, so the remainder lands in [0, 2Q) and one subtract finishes it.
  localparam logic [12:0] BARRETT_M = 13'd5039;

  logic [23:0] prod;
  logic [12:0] qhat;
  logic [12:0] rem;

  always_comb begin
    prod = 24'(a) * 24'(b);
    qhat = 13'((37'(prod) * 37'(BARRETT_M)) >> 24);
    rem  = 13'(prod - 24'(qhat) * 24'(Q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r <= '0;
    else        r <= reduce_once(rem);
  end

endmodule

// File: rtl/kyber_bram_engine.sv
// Memory-mapped Kyber coefficient engine.
//   port1_* : input memory, 1024 x 32, host read/write (writes blocked while busy)
//   port0_* : output memory, 1024 x 32, host read only
//   port2_* : CSRs: 1 = CTRL (bit0 start), 3 = MODE[1:0], 4 = STATUS {busy, done}
//   portN_rst clears only that port's registered read data.
// A 0->1 write of CTRL.bit0 while idle sweeps all words applying the MODE
// operation mod Q from the input memory into the output memory.
module kyber_bram_engine
  import kyber_bram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     port0_addr,
  input  logic [31:0]       port0_din,
  output logic [31:0]       port0_dout,
  input  logic              port0_en,
  input  logic [3:0]        port0_we,
  input  logic              port0_rst,
  input  logic [AW-1:0]     port1_addr,
  input  logic [31:0]       port1_din,
  output logic [31:0]       port1_dout,
  input  logic              port1_en,
  input  logic [3:0]        port1_we,
  input  logic              port1_rst,
  input  logic [CSR_AW-1:0] port2_addr,
  input  logic [31:0]       port2_din,
  output logic [31:0]       port2_dout,
  input  logic              port2_en,
  input  logic [3:0]        port2_we,
  input  logic              port2_rst
);

  logic [31:0] in_mem  [DEPTH];
  logic [31:0] out_mem [DEPTH];

  state_t      state;
  logic [AW-1:0] idx;
  logic        ctrl;
  logic [1:0]  mode;
  logic        done;
  logic        busy;
  logic [31:0] eng_in;
  logic [31:0] eng_out;
  logic [11:0] op_a;
  logic [11:0] op_b;
  logic [11:0] sum_r;
  logic [11:0] prod_r;
  logic [11:0] result;
  logic [31:0] csr_rdata;
  logic        csr_wr;
  logic        start_req;

  // Port 0 host writes and unimplemented CSR bits are deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^{port0_din, port0_we, port2_din[31:2], port2_we[3:1],
                         eng_in[31:12], eng_out[31:12]};

  // Input memory: host port plus the engine's read port.
  always_ff @(posedge clk) begin
    if (port1_en && !busy) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (port1_we[k]) in_mem[port1_addr][8*k +: 8] <= port1_din[8*k +: 8];
      end
    end
    eng_in <= in_mem[idx];
  end

  // Output memory: engine owns the write port and one read port.
  always_ff @(posedge clk) begin
    if (state == ST_WR) out_mem[idx] <= {20'b0, result};
    eng_out <= out_mem[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        port0_dout <= '0;
    else if (port0_rst) port0_dout <= '0;
    else if (port0_en)  port0_dout <= out_mem[port0_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        port1_dout <= '0;
    else if (port1_rst) port1_dout <= '0;
    else if (port1_en)  port1_dout <= in_mem[port1_addr];
  end

  always_comb begin
    csr_rdata = '0;
    case (port2_addr)
      ADDR_CTRL:   csr_rdata[0]   = ctrl;
      ADDR_MODE:   csr_rdata[1:0] = mode;
      ADDR_STATUS: csr_rdata[1:0] = {busy, done};
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        port2_dout <= '0;
    else if (port2_rst) port2_dout <= '0;
    else if (port2_en)  port2_dout <= csr_rdata;
  end

  // All CSR fields live in byte lane 0.
  assign csr_wr    = port2_en && port2_we[0];
  assign start_req = csr_wr && (port2_addr == ADDR_CTRL) && port2_din[0] && !ctrl;

  kyber_modmul u_modmul (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (op_a),
    .b     (op_b),
    .r     (prod_r)
  );

  always_comb begin
    case (mode)
      MODE_COPY: result = op_a;
      MODE_ADD:  result = sum_r;
      MODE_MUL:  result = prod_r;
      default:   result = op_a;
    endcase
  end

  // RD presents idx to both memories, WAIT covers read latency and captures
  // reduced operands, CALC feeds adder and multiplier, WR commits the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      ctrl  <= 1'b0;
      mode  <= MODE_COPY;
      done  <= 1'b0;
      busy  <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      sum_r <= '0;
    end else begin
      if (csr_wr && port2_addr == ADDR_CTRL) ctrl <= port2_din[0];
      if (csr_wr && port2_addr == ADDR_MODE && !busy) mode <= port2_din[1:0];
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            busy  <= 1'b1;
            done  <= 1'b0;
            idx   <= '0;
            state <= (mode == MODE_RSVD) ? ST_DONE : ST_RD;
          end
        end
        ST_RD:   state <= ST_WAIT;
        ST_WAIT: begin
          op_a  <= reduce_once({1'b0, eng_in[11:0]});
          op_b  <= reduce_once({1'b0, eng_out[11:0]});
          state <= ST_CALC;
        end
        ST_CALC: begin
          sum_r <= reduce_once({1'b0, op_a} + {1'b0, op_b});
          state <= ST_WR;
        end
        ST_WR: begin
          if (idx == AW'(DEPTH - 1)) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_RD;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_bram_engine.sv
module tb_kyber_bram_engine;
  import kyber_bram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  port0_addr, port1_addr;
  logic [12:0] port2_addr;
  logic [31:0] port0_din, port1_din, port2_din;
  logic [31:0] port0_dout, port1_dout, port2_dout;
  logic        port0_en, port1_en, port2_en;
  logic [3:0]  port0_we, port1_we, port2_we;
  logic        port0_rst, port1_rst, port2_rst;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  int          port_q[$];
  string       tag_q[$];

  logic [31:0] in_m  [1024];
  logic [31:0] out_m [1024];

  always #5 clk = ~clk;

  kyber_bram_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .port0_addr (port0_addr), .port0_din (port0_din), .port0_dout (port0_dout),
    .port0_en   (port0_en),   .port0_we  (port0_we),  .port0_rst  (port0_rst),
    .port1_addr (port1_addr), .port1_din (port1_din), .port1_dout (port1_dout),
    .port1_en   (port1_en),   .port1_we  (port1_we),  .port1_rst  (port1_rst),
    .port2_addr (port2_addr), .port2_din (port2_din), .port2_dout (port2_dout),
    .port2_en   (port2_en),   .port2_we  (port2_we),  .port2_rst  (port2_rst)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endfunction

  function automatic int red(input logic [31:0] x);
    int v;
    v = int'(x[11:0]);
    return (v >= int'(Q)) ? v - int'(Q) : v;
  endfunction

  function automatic void model_run(input int mode);
    int a, b;
    for (int i = 0; i < 1024; i++) begin
      a = red(in_m[i]);
      b = red(out_m[i]);
      case (mode)
        0: out_m[i] = 32'(a);
        1: out_m[i] = 32'((a + b) % int'(Q));
        2: out_m[i] = 32'((a * b) % int'(Q));
        default: ;
      endcase
    end
  endfunction

  task automatic idle_inputs();
    port0_en = 0; port1_en = 0; port2_en = 0;
    port0_we = '0; port1_we = '0; port2_we = '0;
    port0_rst = 0; port1_rst = 0; port2_rst = 0;
    port0_din = '0; port1_din = '0; port2_din = '0;
  endtask

  // One clock: compare any outstanding read result, then release the bus.
  task automatic cyc();
    logic [31:0] e, obs;
    int p;
    string t;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      p = port_q.pop_front();
      t = tag_q.pop_front();
      case (p)
        0:       obs = port0_dout;
        1:       obs = port1_dout;
        default: obs = port2_dout;
      endcase
      check(t, obs, e);
    end
    idle_inputs();
  endtask

  task automatic rd(input int port, input int addr, input logic [31:0] exp, input string tag);
    case (port)
      0:       begin port0_en = 1; port0_addr = 10'(addr); end
      1:       begin port1_en = 1; port1_addr = 10'(addr); end
      default: begin port2_en = 1; port2_addr = 13'(addr); end
    endcase
    exp_q.push_back(exp);
    port_q.push_back(port);
    tag_q.push_back(tag);
    cyc();
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] data, input logic [3:0] we);
    case (port)
      0:       begin port0_en = 1; port0_we = we; port0_addr = 10'(addr); port0_din = data; end
      1:       begin port1_en = 1; port1_we = we; port1_addr = 10'(addr); port1_din = data; end
      default: begin port2_en = 1; port2_we = we; port2_addr = 13'(addr); port2_din = data; end
    endcase
    cyc();
  endtask

  task automatic csr_peek(input logic [12:0] addr, output logic [31:0] v);
    port2_en = 1; port2_addr = addr;
    @(negedge clk);
    v = port2_dout;
    idle_inputs();
  endtask

  task automatic start_run();
    wr(2, ADDR_CTRL, 32'd0, 4'hF);
    wr(2, ADDR_CTRL, 32'd1, 4'hF);
  endtask

  task automatic wait_done(input string tag, input int min_cyc, input int max_cyc);
    logic [31:0] s;
    int n, bad;
    n = 0; bad = 0;
    do begin
      csr_peek(ADDR_STATUS, s);
      n++;
      if (s != 32'd1 && s != 32'd2) bad++;
    end while (s != 32'd1 && n < max_cyc);
    check({tag, "_status_done"}, s, 32'd1);
    check({tag, "_status_only_busy_before"}, 32'(bad), 32'd0);
    check({tag, "_run_length"}, 32'(n >= min_cyc && n <= max_cyc), 32'd1);
  endtask

  task automatic read_all_out(input string tag);
    for (int a = 0; a < 1024; a++) rd(0, a, out_m[a], tag);
  endtask

  initial begin
    idle_inputs();
    port0_addr = '0; port1_addr = '0; port2_addr = '0;
    rst_n = 0;
    port0_en = 1; port1_en = 1; port2_en = 1;
    repeat (3) @(negedge clk);
    check("rst_dout0", port0_dout, 32'd0);
    check("rst_dout1", port1_dout, 32'd0);
    check("rst_dout2", port2_dout, 32'd0);
    idle_inputs();
    rst_n = 1;
    @(negedge clk);
    rd(2, ADDR_CTRL,   32'd0, "rst_ctrl");
    rd(2, ADDR_MODE,   32'd0, "rst_mode");
    rd(2, ADDR_STATUS, 32'd0, "rst_status");

    // Load pattern in[a] = (a-1) mod 1024, then a single-lane write.
    for (int a = 0; a < 1024; a++) begin
      in_m[a] = 32'((a + 1023) % 1024);
      wr(1, a, in_m[a], 4'hF);
    end
    wr(1, 8, 32'hAAAA55FF, 4'b0010);
    in_m[8][15:8] = 8'h55;
    for (int a = 0; a < 1024; a++) rd(1, a, in_m[a], "in_readback");

    // Mode 0 copy.
    wr(2, ADDR_MODE, 32'd0, 4'hF);
    start_run();
    wait_done("m0", 4000, 5130);
    model_run(0);
    read_all_out("m0_out");
    rd(0, 2, 32'd1,    "m0_out2");
    rd(0, 0, 32'd1023, "m0_out0");

    // Mode 1 add, with blocked host activity while busy.
    wr(2, ADDR_MODE, 32'd1, 4'hF);
    start_run();
    rd(2, ADDR_STATUS, 32'd2, "busy_status");
    wr(2, ADDR_MODE, 32'd2, 4'hF);
    rd(2, ADDR_MODE, 32'd1, "mode_locked_busy");
    wr(2, ADDR_CTRL, 32'd0, 4'hF);
    wr(2, ADDR_CTRL, 32'd1, 4'hF);
    wr(1, 1000, 32'h00000ABC, 4'hF);
    rd(1, 1000, in_m[1000], "in_locked_busy");
    wait_done("m1", 3900, 5130);
    model_run(1);
    read_all_out("m1_out");
    rd(0, 2, 32'd2,    "m1_out2");
    rd(0, 3, 32'd4,    "m1_out3");
    rd(0, 0, 32'd2046, "m1_out0");

    // Mode 2 multiply.
    wr(2, ADDR_MODE, 32'd2, 4'hF);
    start_run();
    wait_done("m2", 4000, 5130);
    model_run(2);
    read_all_out("m2_out");
    rd(0, 2, 32'd2,    "m2_out2");
    rd(0, 3, 32'd8,    "m2_out3");
    rd(0, 0, 32'd2446, "m2_out0");

    // Host writes that must have no effect.
    wr(0, 2, 32'hFFFFFFFF, 4'hF);
    rd(0, 2, out_m[2], "p0_write_ignored");
    wr(2, 13'h3F, 32'h00ADBEEF, 4'hF);
    rd(2, 13'h3F, 32'd0, "csr_3f_reads0");
    rd(2, ADDR_MODE, 32'd2, "mode_after_3f");
    rd(2, ADDR_CTRL, 32'd1, "ctrl_after_3f");

    // Per-port synchronous dout clear.
    rd(0, 3, out_m[3], "pre_clr_p0");
    rd(1, 2, in_m[2],  "pre_clr_p1");
    rd(2, ADDR_STATUS, 32'd1, "pre_clr_p2");
    port1_rst = 1;
    @(negedge clk);
    check("clr1_p1", port1_dout, 32'd0);
    check("clr1_p0", port0_dout, out_m[3]);
    check("clr1_p2", port2_dout, 32'd1);
    idle_inputs();
    port0_rst = 1;
    @(negedge clk);
    check("clr0_p0", port0_dout, 32'd0);
    check("clr0_p2", port2_dout, 32'd1);
    idle_inputs();
    port2_rst = 1;
    @(negedge clk);
    check("clr2_p2", port2_dout, 32'd0);
    idle_inputs();

    // Unreduced inputs in copy mode.
    in_m[4] = 32'd3329;
    in_m[5] = 32'h00000FFF;
    wr(1, 4, in_m[4], 4'hF);
    wr(1, 5, in_m[5], 4'hF);
    wr(2, ADDR_MODE, 32'd0, 4'hF);
    start_run();
    wait_done("m0b", 4000, 5130);
    model_run(0);
    rd(0, 4, 32'd0,   "unreduced_q");
    rd(0, 5, 32'd766, "unreduced_fff");
    rd(0, 6, out_m[6], "m0b_out6");

    // Reserved mode: quick completion, no writes.
    wr(2, ADDR_MODE, 32'd3, 4'hF);
    start_run();
    wait_done("m3", 1, 3);
    rd(0, 4, 32'd0,    "m3_out4_kept");
    rd(0, 6, out_m[6], "m3_out6_kept");

    // Reset in the middle of an add run.
    wr(2, ADDR_MODE, 32'd1, 4'hF);
    start_run();
    repeat (100) cyc();
    rd(0, 1000, out_m[1000], "midrun_p0");
    rd(1, 2, in_m[2], "midrun_p1");
    rd(2, ADDR_STATUS, 32'd2, "midrun_status");
    rst_n = 0;
    #1;
    check("abort_dout0", port0_dout, 32'd0);
    check("abort_dout1", port1_dout, 32'd0);
    check("abort_dout2", port2_dout, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    rd(2, ADDR_STATUS, 32'd0, "abort_status");
    rd(2, ADDR_MODE,   32'd0, "abort_mode");
    rd(2, ADDR_CTRL,   32'd0, "abort_ctrl");
    for (int i = 0; i < 10; i++)
      rd(0, i, 32'((red(in_m[i]) + red(out_m[i])) % int'(Q)), "abort_partial_done");
    for (int i = 500; i < 510; i++)
      rd(0, i, out_m[i], "abort_untouched");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
